// File: rtl/binary_to_gray_counter.sv
// -----------------------------------------------------------------------------
// binary_to_gray_counter
//
// Up/down binary counter whose count is also presented as a registered Gray
// code. Both outputs are taken directly from flops, so gray can be synchronised
// straight into another clock domain (e.g. async-FIFO pointers).
//
// Build option: define BIN2GRAY_SAT_EN for saturating mode. Steps at the
// limits then hold the count, and wrap pulses when a step is blocked. Without
// the macro the counter wraps modulo 2**WIDTH and wrap pulses on each wrap step.
//
// Parameters:
//   WIDTH    counter / code width (2..16)
//   RST_VAL  binary reset count (< 2**WIDTH)
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   en        count enable, one step per cycle
//   up_dn     1 = increment, 0 = decrement (used only when en=1)
//   load      synchronous load strobe (wins over en)
//   load_bin  binary value loaded when load=1
//   binary    registered binary count
//   gray      registered Gray code of binary
//   wrap      one-cycle pulse after a wrap step (saturation hit in sat mode)
//   busy_err  sticky: load and en seen together; cleared only by reset
// -----------------------------------------------------------------------------
module binary_to_gray_counter #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned RST_VAL = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_bin,
    output logic [WIDTH-1:0] binary,
    output logic [WIDTH-1:0] gray,
    output logic             wrap,
    output logic             busy_err
);

`ifdef BIN2GRAY_SAT_EN
    localparam bit SatEn = 1'b1;
`else
    localparam bit SatEn = 1'b0;
`endif

    localparam logic [WIDTH-1:0] RstBin  = RST_VAL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] RstGray = RstBin ^ (RstBin >> 1);
    localparam logic [WIDTH-1:0] MaxVal  = '1;

    logic [WIDTH-1:0] bin_q, bin_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic             wrap_q, wrap_d;
    logic             err_q, err_d;

    logic             at_limit;
    logic [WIDTH-1:0] step_val;

    // A step is at its limit when it would cross the 0 / 2**WIDTH-1 boundary.
    assign at_limit = up_dn ? (bin_q == MaxVal) : (bin_q == '0);
    assign step_val = up_dn ? (bin_q + 1'b1) : (bin_q - 1'b1);

    always_comb begin
        bin_d  = bin_q;
        wrap_d = 1'b0;
        err_d  = err_q;
        if (load) begin
            bin_d = load_bin;
            if (en) begin
                err_d = 1'b1;
            end
        end else if (en) begin
            // Same flag serves as wrap pulse (modulo) or saturation hit (sat).
            wrap_d = at_limit;
            if (!(SatEn && at_limit)) begin
                bin_d = step_val;
            end
        end
        // Gray derived from the next binary so both registers stay in step.
        gray_d = bin_d ^ (bin_d >> 1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q  <= RstBin;
            gray_q <= RstGray;
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            wrap_q <= wrap_d;
            err_q  <= err_d;
        end
    end

    assign binary   = bin_q;
    assign gray     = gray_q;
    assign wrap     = wrap_q;
    assign busy_err = err_q;

endmodule

// File: tb/tb_binary_to_gray_counter.sv
// -----------------------------------------------------------------------------
// tb_binary_to_gray_counter
//
// Directed self-checking bench for binary_to_gray_counter (WIDTH=4, RST_VAL=0).
// Inputs are driven 1 time unit after the rising edge and outputs are sampled
// at that same point, away from the active edge.
// -----------------------------------------------------------------------------
module tb_binary_to_gray_counter;

    localparam int unsigned W = 4;

    logic         clk;
    logic         rst_n;
    logic         en;
    logic         up_dn;
    logic         load;
    logic [W-1:0] load_bin;
    logic [W-1:0] binary;
    logic [W-1:0] gray;
    logic         wrap;
    logic         busy_err;

    int n_tests = 0;
    int n_fail  = 0;

    // Hand-written reflected Gray sequence for counts 0..16 (16 wraps to 0).
    localparam int GraySeq [0:16] = '{
        4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
        4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000,
        4'b0000
    };

    binary_to_gray_counter #(
        .WIDTH   (W),
        .RST_VAL (0)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .up_dn    (up_dn),
        .load     (load),
        .load_bin (load_bin),
        .binary   (binary),
        .gray     (gray),
        .wrap     (wrap),
        .busy_err (busy_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input int b, input int g, input int w);
        check({tag, ".bin"}, int'(binary), b);
        check({tag, ".gray"}, int'(gray), g);
        check({tag, ".wrap"}, int'(wrap), w);
    endtask

    initial begin
        logic [W-1:0] prev_gray;

        rst_n    = 1'b0;
        en       = 1'b0;
        up_dn    = 1'b0;
        load     = 1'b0;
        load_bin = '0;

        // Reset values visible before any clock edge.
        #3;
        check_state("reset", 0, 0, 0);
        check("reset.busy", int'(busy_err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check_state("idle", 0, 0, 0);

`ifndef BIN2GRAY_SAT_EN
        // Full up count with wrap.
        en    = 1'b1;
        up_dn = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            prev_gray = gray;
            step();
            check($sformatf("up%0d.bin", i), int'(binary), i % 16);
            check($sformatf("up%0d.gray", i), int'(gray), GraySeq[i]);
            check($sformatf("up%0d.onebit", i), $countones(gray ^ prev_gray), 1);
            check($sformatf("up%0d.wrap", i), int'(wrap), (i == 16) ? 1 : 0);
        end
        en = 1'b0;
        step();
        check_state("up_hold", 0, 0, 0);

        // Load then count down through zero.
        load     = 1'b1;
        load_bin = 4'b0010;
        step();
        check_state("ld2", 2, 3, 0);
        load  = 1'b0;
        en    = 1'b1;
        up_dn = 1'b0;
        step();
        check_state("dn1", 1, 1, 0);
        step();
        check_state("dn0", 0, 0, 0);
        prev_gray = gray;
        step();
        check_state("dn15", 15, 8, 1);
        check("dn15.onebit", $countones(gray ^ prev_gray), 1);
        en = 1'b0;
        step();
        check_state("dn_hold", 15, 8, 0);
`else
        // Saturating mode: blocked steps hold and pulse wrap.
        load     = 1'b1;
        load_bin = 4'b1111;
        step();
        check_state("sat_ld", 15, 8, 0);
        load  = 1'b0;
        en    = 1'b1;
        up_dn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_state($sformatf("sat_hi%0d", i), 15, 8, 1);
        end
        up_dn = 1'b0;
        step();
        check_state("sat_dn", 14, 9, 0);
        en       = 1'b0;
        load     = 1'b1;
        load_bin = 4'b0000;
        step();
        load = 1'b0;
        en   = 1'b1;
        step();
        check_state("sat_lo", 0, 0, 1);
        en = 1'b0;
        step();
        check_state("sat_lo_hold", 0, 0, 0);
`endif

        // Direction reversal with en held.
        load     = 1'b1;
        load_bin = 4'b0101;
        step();
        check_state("ld5", 5, 7, 0);
        load  = 1'b0;
        en    = 1'b1;
        up_dn = 1'b1;
        step();
        check_state("rev6", 6, 5, 0);
        step();
        check_state("rev7", 7, 4, 0);
        up_dn = 1'b0;
        step();
        check_state("rev_dn6", 6, 5, 0);

        // Idle: up_dn and load_bin are don't-care.
        en       = 1'b0;
        up_dn    = 1'b1;
        load_bin = 4'b1001;
        step();
        up_dn    = 1'b0;
        load_bin = 4'b0110;
        step();
        check_state("xsafe", 6, 5, 0);
        check("xsafe.busy", int'(busy_err), 0);

        // Load/en collision: load wins, busy_err sticks.
        load     = 1'b1;
        en       = 1'b1;
        up_dn    = 1'b1;
        load_bin = 4'b1010;
        step();
        check_state("coll", 10, 15, 0);
        check("coll.busy", int'(busy_err), 1);
        load = 1'b0;
        en   = 1'b0;
        step();
        check("coll.busy_hold", int'(busy_err), 1);
        en = 1'b1;
        step();
        check_state("coll_up", 11, 14, 0);
        check("coll_up.busy", int'(busy_err), 1);

        // Reset mid-cycle right after a limit step: pending wrap discarded.
        en       = 1'b0;
        load     = 1'b1;
        load_bin = 4'b1111;
        step();
        load  = 1'b0;
        en    = 1'b1;
        up_dn = 1'b1;
        step();
        check("pre_rst.wrap", int'(wrap), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_state("mid_rst", 0, 0, 0);
        check("mid_rst.busy", int'(busy_err), 0);
        en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check_state("post_rst", 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Safety net so the bench can never hang.
    initial begin
        #100000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule
